// File: rtl/sample2uart_pkg.sv
// Shared types and helpers for the multichannel sample-to-UART serialiser.
package sample2uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOAD,
    WAIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int nbytes(input int bps);
    return (bps + 7) / 8;
  endfunction

endpackage

// File: rtl/multichannel_sample2uart_if.sv
// Sample-switch / UART side signals of the serialiser; slave = serialiser, master = its environment.
interface multichannel_sample2uart_if #(
  parameter int BPS      = 24,
  parameter int CHANNELS = 2
);
  logic                    in_en;
  logic                    tx_busy;
  logic [BPS*CHANNELS-1:0] in_sample;
  logic [7:0]              out_uart_frame;
  logic                    out_ready_uart;
  logic                    out_ready_sample_switch;
  logic                    out_frame_done;

  modport slave (
    input  in_en, tx_busy, in_sample,
    output out_uart_frame, out_ready_uart, out_ready_sample_switch, out_frame_done
  );

  modport master (
    output in_en, tx_busy, in_sample,
    input  out_uart_frame, out_ready_uart, out_ready_sample_switch, out_frame_done
  );
endinterface

// File: rtl/uart_byte_handshake.sv
// Registers the one-cycle UART strobe for a byte request, then reports byte_done once
// tx_busy has been sampled low on two consecutive cycles; holds forever while tx_busy stays high.
module uart_byte_handshake (
  input  logic in_clk,
  input  logic in_rst,
  input  logic req_i,
  input  logic tx_busy_i,
  output logic ready_uart_o,
  output logic byte_done_o
);

  logic active_q, active_d;
  logic guard_q, guard_d;
  logic ready_q;

  // guard_q remembers one low sample; the UART may raise busy a cycle after the strobe
  always_comb begin
    byte_done_o = active_q & guard_q & ~tx_busy_i;
    active_d    = active_q;
    guard_d     = ~tx_busy_i;
    if (req_i) begin
      active_d = 1'b1;
      guard_d  = 1'b0;
    end else if (byte_done_o) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      active_q <= 1'b0;
      guard_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      guard_q  <= guard_d;
      ready_q  <= req_i;
    end
  end

  assign ready_uart_o = ready_q;

endmodule

// File: rtl/multichannel_sample2uart.sv
// Serialises CHANNELS samples of BPS bits into UART bytes, min 3 cycles/byte, paced by tx_busy.
// Optional frame-leading sync byte when SAMPLE2UART_SYNC_EN is defined.
module multichannel_sample2uart
  import sample2uart_pkg::*;
#(
  parameter int BPS       = 24,
  parameter int CHANNELS  = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  multichannel_sample2uart_if.slave    bus
);

  localparam int NB = nbytes(BPS);

  state_t                  state_q, state_d;
  logic [BPS*CHANNELS-1:0] sample_q, sample_d;
  logic [2:0]              byte_idx_q, byte_idx_d;
  logic [2:0]              ch_idx_q, ch_idx_d;
  logic [7:0]              frame_q, frame_d;
  logic                    rdy_q, rdy_d;
  logic                    done_q, done_d;
  logic                    load_req;
  logic                    hs_done;
  logic                    hs_ready;
  logic [BPS-1:0]          chan;
  logic [NB*8-1:0]         ext;
  int                      sel;
`ifdef SAMPLE2UART_SYNC_EN
  logic                    sync_q, sync_d;
`endif

  always_comb begin
    chan           = sample_q[int'(ch_idx_q)*BPS +: BPS];
    ext            = '0;
    ext[BPS-1:0]   = chan;
    sel            = (MSB_FIRST != 0) ? (NB - 1 - int'(byte_idx_q)) : int'(byte_idx_q);
  end

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    byte_idx_d = byte_idx_q;
    ch_idx_d   = ch_idx_q;
    frame_d    = frame_q;
    rdy_d      = rdy_q;
    done_d     = 1'b0;
    load_req   = 1'b0;
`ifdef SAMPLE2UART_SYNC_EN
    sync_d     = sync_q;
`endif
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (bus.in_en && !bus.tx_busy && rdy_q) begin
          sample_d   = bus.in_sample;
          rdy_d      = 1'b0;
          byte_idx_d = '0;
          ch_idx_d   = '0;
`ifdef SAMPLE2UART_SYNC_EN
          state_d    = SYNC;
`else
          state_d    = LOAD;
`endif
        end
      end
`ifdef SAMPLE2UART_SYNC_EN
      SYNC: begin
        frame_d  = SYNC_BYTE;
        load_req = 1'b1;
        sync_d   = 1'b1;
        state_d  = WAIT;
      end
`endif
      LOAD: begin
        frame_d  = ext[8*sel +: 8];
        load_req = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (hs_done) begin
`ifdef SAMPLE2UART_SYNC_EN
          sync_d = 1'b0;
          // the sync byte does not consume a data byte slot
          if (sync_q) state_d = LOAD; else
`endif
          begin
            state_d = LOAD;
            if (byte_idx_q == 3'(NB - 1)) begin
              byte_idx_d = '0;
              if (ch_idx_q == 3'(CHANNELS - 1)) begin
                ch_idx_d = '0;
                state_d  = IDLE;
                done_d   = 1'b1;
                rdy_d    = 1'b1;
              end else begin
                ch_idx_d = ch_idx_q + 3'd1;
              end
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      byte_idx_q <= '0;
      ch_idx_q   <= '0;
      frame_q    <= 8'h00;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
`ifdef SAMPLE2UART_SYNC_EN
      sync_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      byte_idx_q <= byte_idx_d;
      ch_idx_q   <= ch_idx_d;
      frame_q    <= frame_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
`ifdef SAMPLE2UART_SYNC_EN
      sync_q     <= sync_d;
`endif
    end
  end

  uart_byte_handshake u_hs (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .req_i        (load_req),
    .tx_busy_i    (bus.tx_busy),
    .ready_uart_o (hs_ready),
    .byte_done_o  (hs_done)
  );

  assign bus.out_uart_frame          = frame_q;
  assign bus.out_ready_uart          = hs_ready;
  assign bus.out_ready_sample_switch = rdy_q;
  assign bus.out_frame_done          = done_q;

endmodule

// File: tb/tb_multichannel_sample2uart.sv
// Directed bench for multichannel_sample2uart: three configurations, UART busy model in the stimulus loop.
module tb_multichannel_sample2uart;

`ifdef SAMPLE2UART_SYNC_EN
  localparam int SYNC_N = 1;
`else
  localparam int SYNC_N = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en   [3];
  logic        busy [3];
  logic [47:0] smp  [3];
  logic        stb  [3];
  logic [7:0]  dat  [3];
  logic        rss  [3];
  logic        fdone[3];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  multichannel_sample2uart_if #(.BPS(24), .CHANNELS(2)) if0 ();
  multichannel_sample2uart_if #(.BPS(24), .CHANNELS(2)) if1 ();
  multichannel_sample2uart_if #(.BPS(12), .CHANNELS(1)) if2 ();

  multichannel_sample2uart #(.BPS(24), .CHANNELS(2), .MSB_FIRST(0)) u0 (.in_clk(clk), .in_rst(rst), .bus(if0));
  multichannel_sample2uart #(.BPS(24), .CHANNELS(2), .MSB_FIRST(1)) u1 (.in_clk(clk), .in_rst(rst), .bus(if1));
  multichannel_sample2uart #(.BPS(12), .CHANNELS(1), .MSB_FIRST(0)) u2 (.in_clk(clk), .in_rst(rst), .bus(if2));

  assign if0.in_en = en[0];  assign if0.tx_busy = busy[0];  assign if0.in_sample = smp[0];
  assign if1.in_en = en[1];  assign if1.tx_busy = busy[1];  assign if1.in_sample = smp[1];
  assign if2.in_en = en[2];  assign if2.tx_busy = busy[2];  assign if2.in_sample = smp[2][11:0];

  assign stb[0] = if0.out_ready_uart;  assign dat[0] = if0.out_uart_frame;
  assign rss[0] = if0.out_ready_sample_switch;  assign fdone[0] = if0.out_frame_done;
  assign stb[1] = if1.out_ready_uart;  assign dat[1] = if1.out_uart_frame;
  assign rss[1] = if1.out_ready_sample_switch;  assign fdone[1] = if1.out_frame_done;
  assign stb[2] = if2.out_ready_uart;  assign dat[2] = if2.out_uart_frame;
  assign rss[2] = if2.out_ready_sample_switch;  assign fdone[2] = if2.out_frame_done;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Runs one frame on DUT d. The UART model holds busy for blen cycles per strobe.
  // Optionally holds busy for 100 cycles after strobe number stall_at, with in_en asserted.
  task automatic run_frame(input int d, input logic [47:0] s, input logic [63:0] expv, input int n,
                           input int blen, input int stall_at, input int pre_busy, input string tag);
    int k, nd, cnt, last, acc, done_at, guard, nstall;
    logic [63:0] e;
    int ne;
    if (SYNC_N != 0) e = {expv[55:0], 8'hA5};
    else e = expv;
    ne = n + SYNC_N;
    smp[d]  = s;
    en[d]   = 1'b1;
    busy[d] = (pre_busy > 0);
    for (int i = 0; i < pre_busy; i++) begin
      tick();
      check($sformatf("%s_busy_no_accept", tag), rss[d], 1);
    end
    busy[d] = 1'b0;
    tick();
    check($sformatf("%s_accept", tag), rss[d], 0);
    en[d] = 1'b0;
    acc = cyc; k = 0; nd = 0; cnt = 0; done_at = -1; last = 0; guard = 0;
    while (guard < 3000 && !(done_at >= 0 && cyc >= done_at + 20)) begin
      tick();
      guard++;
      if (stb[d]) begin
        if (k == 0) check($sformatf("%s_first_latency", tag), cyc - acc, 1);
        else check($sformatf("%s_gap%0d", tag, k), cyc - last, blen + 3);
        if (k < ne) check($sformatf("%s_byte%0d", tag, k), dat[d], e[8*k +: 8]);
        k++;
        last = cyc;
        cnt  = blen;
        if (k == stall_at) begin
          busy[d] = 1'b1;
          en[d]   = 1'b1;
          smp[d]  = ~s;
          nstall  = 0;
          for (int i = 0; i < 100; i++) begin
            tick();
            if (stb[d]) nstall++;
          end
          check($sformatf("%s_stall_no_strobe", tag), nstall, 0);
          check($sformatf("%s_stall_busy_switch", tag), rss[d], 0);
          busy[d] = 1'b0;
          en[d]   = 1'b0;
          smp[d]  = s;
          last    = cyc;
        end
      end
      if (fdone[d]) begin
        nd++;
        if (done_at < 0) begin
          done_at = cyc;
          check($sformatf("%s_done_latency", tag), cyc - last, blen + 2);
          check($sformatf("%s_done_ready", tag), rss[d], 1);
        end
      end
      busy[d] = (cnt != 0);
      if (cnt != 0) cnt--;
    end
    check($sformatf("%s_completed", tag), done_at >= 0, 1);
    check($sformatf("%s_strobe_count", tag), k, ne);
    check($sformatf("%s_done_pulses", tag), nd, 1);
  endtask

  initial begin
    int k, cnt, nrst;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; busy[d] = 1'b0; smp[d] = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_frame%0d", d), dat[d], 8'h00);
      check($sformatf("rst_strobe%0d", d), stb[d], 0);
      check($sformatf("rst_done%0d", d), fdone[d], 0);
      check($sformatf("rst_ready%0d", d), rss[d], 1);
    end
    rst = 1'b0;
    tick();

    run_frame(0, 48'hABCDEF_123456, 64'h0000_ABCDEF_123456, 6, 10, -1, 3, "lsb24x2");
    run_frame(1, 48'hABCDEF_123456, 64'h0000_EFCDAB_563412, 6, 10, -1, 0, "msb24x2");
    run_frame(2, 48'h0000_0000_0ABC, 64'h0000_0000_0000_0ABC, 2, 10, -1, 0, "pad12x1");
    run_frame(0, 48'h0011FF_80007F, 64'h0000_0011FF_80007F, 6, 0, -1, 0, "minperiod");

    // Reset in the WAIT that follows the fourth strobe.
    smp[0] = 48'h654321_FEDCBA;
    en[0]  = 1'b1;
    tick();
    en[0] = 1'b0;
    k = 0; cnt = 0;
    for (int i = 0; i < 500 && k < 4; i++) begin
      tick();
      if (stb[0]) begin k++; cnt = 10; end
      busy[0] = (cnt != 0);
      if (cnt != 0) cnt--;
    end
    check("rst_mid_reached", k, 4);
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    busy[0] = 1'b0;
    check("rst_mid_ready", rss[0], 1);
    check("rst_mid_strobe", stb[0], 0);
    check("rst_mid_frame", dat[0], 8'h00);
    nrst = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stb[0]) nrst++;
    end
    check("rst_mid_no_strobes", nrst, 0);
    run_frame(0, 48'hABCDEF_123456, 64'h0000_ABCDEF_123456, 6, 10, -1, 0, "after_rst");

    run_frame(1, 48'hABCDEF_123456, 64'h0000_EFCDAB_563412, 6, 0, 2, 0, "stall");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
